// File: rtl/operand2_shifter.sv
// Registered second-operand unit: rotated immediates, load/store offsets and ARM shifts.
// Optional register-amount shifts are enabled by defining OPERAND2_REG_SHIFT_EN.
module operand2_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_imm,
    input  logic             in_mem_cmd,
    input  logic [11:0]      in_shift_operand,
    input  logic [WIDTH-1:0] in_val_rm,
    input  logic [7:0]       in_val_rs,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val2,
    output logic             out_carry
);
    localparam int SHW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] ror_f(input logic [WIDTH-1:0] x, input logic [SHW-1:0] r);
        return (x >> r) | (x << (SHW'(WIDTH) - r));
    endfunction

    logic [11:0]      so;
    logic [1:0]       sh_type;
    logic             use_rs;
    logic [7:0]       amt;
    logic [7:0]       n;
    logic [WIDTH:0]   lsl_w;
    logic [WIDTH:0]   lsr_w;
    logic [WIDTH:0]   asr_w;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] imm_v;
    logic [WIDTH-1:0] nxt_val2;
    logic             nxt_carry;
    logic             accept;

    assign so      = in_shift_operand;
    assign sh_type = so[6:5];

`ifdef OPERAND2_REG_SHIFT_EN
    assign use_rs = so[4];
    assign amt    = use_rs ? in_val_rs : {3'b000, so[11:7]};
`else
    logic unused_rs;
    assign unused_rs = ^in_val_rs;
    assign use_rs    = 1'b0;
    assign amt       = {3'b000, so[11:7]};
`endif

    // Immediate LSR #0 / ASR #0 mean a shift by WIDTH.
    assign n = (!use_rs && amt == 8'd0 && (sh_type == 2'b01 || sh_type == 2'b10)) ? 8'(WIDTH) : amt;

    // One extra bit on the exit side captures the last bit shifted out; oversize n drains to 0/sign.
    assign lsl_w = {1'b0, in_val_rm} << n;
    assign lsr_w = {in_val_rm, 1'b0} >> n;
    assign asr_w = $signed({in_val_rm, 1'b0}) >>> n;
    assign ror_v = ror_f(in_val_rm, {1'b0, n[SHW-2:0]});
    assign imm_v = ror_f({{(WIDTH-8){1'b0}}, so[7:0]}, SHW'({so[11:8], 1'b0}));

    always_comb begin
        nxt_val2  = in_val_rm;
        nxt_carry = in_carry;
        if (in_mem_cmd) begin
            nxt_val2  = {{(WIDTH-12){1'b0}}, so};
            nxt_carry = in_carry;
        end else if (in_imm) begin
            nxt_val2  = imm_v;
            nxt_carry = (so[11:8] == 4'd0) ? in_carry : imm_v[WIDTH-1];
        end else if (n == 8'd0 && (use_rs || sh_type == 2'b00)) begin
            nxt_val2  = in_val_rm;
            nxt_carry = in_carry;
        end else if (n == 8'd0) begin
            // ROR #0 is RRX
            nxt_val2  = {in_carry, in_val_rm[WIDTH-1:1]};
            nxt_carry = in_val_rm[0];
        end else begin
            case (sh_type)
                2'b00: {nxt_carry, nxt_val2} = lsl_w;
                2'b01: {nxt_val2, nxt_carry} = lsr_w;
                2'b10: {nxt_val2, nxt_carry} = asr_w;
                default: begin
                    nxt_val2  = ror_v;
                    nxt_carry = ror_v[WIDTH-1];
                end
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_val2  <= '0;
            out_carry <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_val2  <= nxt_val2;
            out_carry <= nxt_carry;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/operand2_shifter.md
# operand2_shifter

Registered, parametrised second-operand unit for the EX stage.
- Produces Val2 and the shifter carry-out for data-processing and load/store instructions.
- Supports 8-bit rotated immediates, all ARM shift types (LSL, LSR, ASR, ROR, RRX), immediate-amount shifts and, optionally, register-amount shifts.
- Has one pipeline register with a valid/ready handshake and flush, so it can sit between the ID/EX register and the ALU without stalling logic of its own.

## Interface
- WIDTH, 32, datapath width. Legal values are 32 and 64.
- SHW, $clog2(WIDTH)+1, internal shift-amount width. Derived; do not override.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops the held result and any same-cycle input.
- in_valid  input  1  input operands are valid.
- in_ready  output  1  unit can accept input this cycle.
- in_imm  input  1  I bit: use the rotated 8-bit immediate.
- in_mem_cmd  input  1  load/store: Val2 is the 12-bit offset.
- in_shift_operand  input  12  instruction bits [11:0].
- in_val_rm  input  WIDTH  Rm value.
- in_val_rs  input  8  Rs[7:0], used for register-amount shifts.
- in_carry  input  1  current C flag.
- out_valid  output  1  out_val2 and out_carry are valid.
- out_ready  input  1  consumer accepts the output.
- out_val2  output  WIDTH  second operand.
- out_carry  output  1  shifter carry-out.

## Operation
Priority of operand selection, first match wins:
1. in_mem_cmd=1: val2 = zero-extended shift_operand[11:0]; carry = in_carry. The offset is never sign-extended; direction is the U bit's job, not this unit's.
2. in_imm=1: imm8 = so[7:0] zero-extended to WIDTH, rotated right by 2*so[11:8] modulo WIDTH.
   - Carry = in_carry if so[11:8]==0, else val2[WIDTH-1].
3. Otherwise the shift type is so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. The amount n comes from:
   - so[4]=0: imm5 = so[11:7].
   - so[4]=1: in_val_rs[7:0] (this path only exists with the macro, see Configuration).

Immediate-amount rules (so[4]=0):
- LSL #0: val2 = Rm, carry = in_carry.
- LSR #0 and ASR #0 encode n = WIDTH.
- ROR #0 is RRX: val2 = {in_carry, Rm[WIDTH-1:1]}, carry = Rm[0].

Register-amount rules (so[4]=1), with n taken from all 8 bits:
- n=0: val2 = Rm, carry = in_carry, for every type.
- LSL:
  - n<WIDTH: carry = Rm[WIDTH-n].
  - n==WIDTH: val2 = 0, carry = Rm[0].
  - n>WIDTH: val2 = 0, carry = 0.
- LSR: same boundaries as LSL; n==WIDTH gives carry = Rm[WIDTH-1].
- ASR, n>=WIDTH: val2 = all copies of Rm[WIDTH-1], carry = Rm[WIDTH-1].
- ROR: rotate by n mod WIDTH.
  - If n mod WIDTH == 0 (and n != 0): val2 = Rm, carry = Rm[WIDTH-1].
  - Otherwise carry = val2[WIDTH-1].

General shift carry (n in 1..WIDTH-1): carry is the last bit shifted out.

Handshake:
- in_ready = !out_valid || out_ready.
- Accept = in_valid && in_ready && !flush.
- On accept, the result is registered and out_valid=1.
- If out_valid && out_ready with no accept, out_valid drops to 0.
- out_val2 and out_carry hold their value while out_valid && !out_ready, even if inputs change.

## Timing
- Latency is exactly 1 cycle from accept to out_valid.
- Throughput is 1 result per cycle while out_ready=1.
- Reset sets out_valid=0, out_val2=0 and out_carry=0; it takes effect on the next edge and aborts a held result.
- flush=1: on the next edge out_valid=0 and the same-cycle input is discarded; the data registers are don't-care. flush has priority over accept. rst has priority over flush.
- Output registers only; no combinational path from inputs to out_val2 or out_carry.
- in_ready is combinational in out_valid and out_ready only.
- Back-to-back accept with out_ready=1 replaces the result every cycle.

## Configuration
- OPERAND2_REG_SHIFT_EN defined: register-amount shifts follow the rules above.
- OPERAND2_REG_SHIFT_EN undefined:
  - so[4] is ignored; so[11:7] is always decoded as imm5.
  - in_val_rs is unused.
  - The unit is smaller and has a shorter shift-amount mux.

## Test plan
- Immediate: in_imm=1, so=12'h4FF, in_carry=0 -> out_val2=32'hFF000000, out_carry=1, one cycle after accept.
- Load/store: in_mem_cmd=1, so=12'hFFC -> out_val2=32'h00000FFC (zero-extended), out_carry=in_carry.
- Immediate shifts, Rm=32'h80000001, C=1:
  - LSR #0 -> val2=0, carry=1.
  - ASR #0 -> val2=32'hFFFFFFFF, carry=1.
  - RRX -> val2=32'hC0000000, carry=1.
  - LSL #1 -> val2=32'h00000002, carry=1.
- Register shifts (macro on), Rm=32'h0000000F:
  - LSL Rs=32 -> val2=0, carry=1.
  - LSL Rs=33 -> val2=0, carry=0.
  - ROR Rs=4 -> val2=32'hF0000000, carry=1.
  - Rs=0 -> val2=Rm, carry=in_carry.
  - Macro off: the same encoding decodes so[11:7] as imm5.
- Handshake:
  - out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and output held stable.
  - out_ready rises -> next result appears on the next edge with no loss or duplication.
- flush and reset:
  - flush with in_valid=1 -> out_valid=0 next cycle.
  - rst while out_valid=1 and out_ready=0 -> out_valid=0, out_val2=0, out_carry=0 next cycle.
